// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes, mux/ALU codes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_ctrl_pkg;

  // Controller states; 4-bit encoding leaves two spare codes that recover to RESET.
  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  // Instruction[31:26] opcodes understood by the controller.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // ALUOp codes consumed by ALUcontrol.
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Trap cause codes.
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Datapath control word (ALUOp travels separately since its width is a parameter).
  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write_cond_n;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational state/opcode/mem_ready to control-word decode for the multicycle controller.
// Latency: zero cycles (pure combinational).
// Backpressure: mem_ready gates the FETCH latch strobes and the store retire pulse.
module mips_mc_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  state_e              state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                mem_ready_i,
  output ctrl_t               ctrl_o,
  output logic [ALUOP_W-1:0]  alu_op_o
);

  // Moore decode of the state, with the handshake-gated strobes folded in.
  always_comb begin
    ctrl_o   = '0;
    alu_op_o = ALUOP_W'(ALU_ADD);
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR and PC+4 only latch on the cycle the memory actually returns the word.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is dispatched.
        ctrl_o.alu_src_b = SRCB_IMM_S2;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REGB;
        alu_op_o         = ALUOP_W'(ALU_FUNCT);
      end
      S_R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a       = 1'b1;
        ctrl_o.alu_src_b       = SRCB_REGB;
        ctrl_o.pc_source       = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond   = (opcode_i == OPCODE_W'(OP_BEQ));
        ctrl_o.pc_write_cond_n = (opcode_i == OPCODE_W'(OP_BNE));
        ctrl_o.instr_done      = 1'b1;
        alu_op_o               = ALUOP_W'(ALU_SUB);
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        if (opcode_i == OPCODE_W'(OP_ANDI)) begin
          alu_op_o = ALUOP_W'(ALU_AND);
        end else if (opcode_i == OPCODE_W'(OP_ORI)) begin
          alu_op_o = ALUOP_W'(ALU_OR);
        end else if (opcode_i == OPCODE_W'(OP_SLTI)) begin
          alu_op_o = ALUOP_W'(ALU_SLT);
        end else begin
          alu_op_o = ALUOP_W'(ALU_ADD);
        end
      end
      S_I_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: begin
        // RESET, TRAP and spare codes drive an all-quiet datapath.
        ctrl_o   = '0;
        alu_op_o = ALUOP_W'(ALU_ADD);
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_control_p.sv
// Multicycle MIPS main-control FSM with memory handshake, wait timeout and sticky trap.
// Latency: lw 5, sw/R/I 4, beq/bne/j 3 cycles; each mem_ready=0 wait cycle adds one.
// Backpressure: FETCH/MEM_READ/MEM_WRITE stall on mem_ready=0 and trap after MEM_TIMEOUT waits.
module mips_mc_control_p
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int EN_IMM_OPS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWriteCond,
  output logic                PCWriteCondN,
  output logic                PCWrite,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic [1:0]          PCSource,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          ALUSrcB,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  // Wide enough to reach MEM_TIMEOUT; with the timeout disabled the counter may wrap harmlessly.
  localparam int WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              trap_q, trap_d;
  logic [1:0]        trap_cause_q, trap_cause_d;

  ctrl_t             ctrl;
  logic              in_wait_state;
  logic              timeout;
  logic              is_imm_op;

  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                         (state_q == S_MEM_WRITE);

  // mem_ready takes priority over an expiring wait count.
  assign timeout = (MEM_TIMEOUT > 0) && !mem_ready &&
                   (wait_cnt_q == WCNT_W'(MEM_TIMEOUT));

  assign is_imm_op = (EN_IMM_OPS != 0) &&
                     ((opcode == OPCODE_W'(OP_ADDI)) || (opcode == OPCODE_W'(OP_ANDI)) ||
                      (opcode == OPCODE_W'(OP_ORI))  || (opcode == OPCODE_W'(OP_SLTI)));

  mips_mc_ctrl_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl),
    .alu_op_o    (ALUOp)
  );

  assign PCWriteCond  = ctrl.pc_write_cond;
  assign PCWriteCondN = ctrl.pc_write_cond_n;
  assign PCWrite      = ctrl.pc_write;
  assign IorD         = ctrl.i_or_d;
  assign MemRead      = ctrl.mem_read;
  assign MemWrite     = ctrl.mem_write;
  assign MemtoReg     = ctrl.mem_to_reg;
  assign IRWrite      = ctrl.ir_write;
  assign PCSource     = ctrl.pc_source;
  assign ALUSrcB      = ctrl.alu_src_b;
  assign ALUSrcA      = ctrl.alu_src_a;
  assign RegWrite     = ctrl.reg_write;
  assign RegDst       = ctrl.reg_dst;
  assign instr_done   = ctrl.instr_done;
  assign trap         = trap_q;
  assign trap_cause   = trap_cause_q;

  // Next-state, trap capture and wait-counter update.
  always_comb begin
    state_d      = state_q;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (opcode == OPCODE_W'(OP_RTYPE)) begin
          state_d = S_R_EXEC;
        end else if ((opcode == OPCODE_W'(OP_LW)) || (opcode == OPCODE_W'(OP_SW))) begin
          state_d = S_MEM_ADDR;
        end else if ((opcode == OPCODE_W'(OP_BEQ)) || (opcode == OPCODE_W'(OP_BNE))) begin
          state_d = S_BRANCH;
        end else if (opcode == OPCODE_W'(OP_J)) begin
          state_d = S_JUMP;
        end else if (is_imm_op) begin
          state_d = S_I_EXEC;
        end else begin
          state_d      = S_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_ILLEGAL;
        end
      end
      S_MEM_ADDR: state_d = (opcode == OPCODE_W'(OP_LW)) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WB: state_d = S_FETCH;
      S_R_EXEC: state_d = S_R_WB;
      S_R_WB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_I_EXEC: state_d = S_I_WB;
      S_I_WB:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase

    // Count consecutive stalled cycles; any state change restarts the count.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (in_wait_state && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + WCNT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State, wait counter and sticky trap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      wait_cnt_q   <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
    end
  end

endmodule

// File: tb/tb_mips_mc_control_p.sv
// Scoreboard bench for mips_mc_control_p: stimulus pushes hand-derived expected control words.
// Latency: one expected word per clock; the monitor compares at the falling edge.
// Backpressure: mem_ready is driven per cycle from the directed vectors.
module tb_mips_mc_control_p;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWriteCond, PCWriteCondN, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUSrcB, trap_cause;
  logic [2:0] ALUOp;
  logic       ALUSrcA, RegWrite, RegDst, instr_done, trap;

  typedef struct packed {
    logic       pcwc, pcwcn, pcw, iord, mr, mw, m2r, irw;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic [1:0] srcb;
    logic       srca, rw, rd, done, trp;
    logic [1:0] cause;
  } vec_t;

  vec_t  got;
  vec_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010, ILL = 6'b111111;

  always #5 clk = ~clk;

  mips_mc_control_p #(
    .OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(15), .EN_IMM_OPS(1)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWriteCond(PCWriteCond), .PCWriteCondN(PCWriteCondN), .PCWrite(PCWrite),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst), .instr_done(instr_done),
    .trap(trap), .trap_cause(trap_cause)
  );

  assign got = {PCWriteCond, PCWriteCondN, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, instr_done, trap, trap_cause};

  // Expected control words, written out per state from the control table.
  function automatic vec_t v_zero();
    vec_t v = '0;
    return v;
  endfunction
  function automatic vec_t v_fetch(input logic rdy);
    vec_t v = '0;
    v.mr = 1'b1; v.srcb = 2'b01; v.irw = rdy; v.pcw = rdy;
    return v;
  endfunction
  function automatic vec_t v_decode();
    vec_t v = '0;
    v.srcb = 2'b11;
    return v;
  endfunction
  function automatic vec_t v_memaddr();
    vec_t v = '0;
    v.srca = 1'b1; v.srcb = 2'b10;
    return v;
  endfunction
  function automatic vec_t v_memread();
    vec_t v = '0;
    v.mr = 1'b1; v.iord = 1'b1;
    return v;
  endfunction
  function automatic vec_t v_memwb();
    vec_t v = '0;
    v.rw = 1'b1; v.m2r = 1'b1; v.done = 1'b1;
    return v;
  endfunction
  function automatic vec_t v_memwrite(input logic rdy);
    vec_t v = '0;
    v.mw = 1'b1; v.iord = 1'b1; v.done = rdy;
    return v;
  endfunction
  function automatic vec_t v_rexec();
    vec_t v = '0;
    v.srca = 1'b1; v.aluop = 3'b010;
    return v;
  endfunction
  function automatic vec_t v_rwb();
    vec_t v = '0;
    v.rw = 1'b1; v.rd = 1'b1; v.done = 1'b1;
    return v;
  endfunction
  function automatic vec_t v_branch(input logic is_bne);
    vec_t v = '0;
    v.srca = 1'b1; v.aluop = 3'b001; v.pcsrc = 2'b01; v.done = 1'b1;
    v.pcwc = !is_bne; v.pcwcn = is_bne;
    return v;
  endfunction
  function automatic vec_t v_jump();
    vec_t v = '0;
    v.pcw = 1'b1; v.pcsrc = 2'b10; v.done = 1'b1;
    return v;
  endfunction
  function automatic vec_t v_iexec(input logic [2:0] aop);
    vec_t v = '0;
    v.srca = 1'b1; v.srcb = 2'b10; v.aluop = aop;
    return v;
  endfunction
  function automatic vec_t v_iwb();
    vec_t v = '0;
    v.rw = 1'b1; v.done = 1'b1;
    return v;
  endfunction
  function automatic vec_t v_trap(input logic [1:0] c);
    vec_t v = '0;
    v.trp = 1'b1; v.cause = c;
    return v;
  endfunction

  // One clock: drive this cycle's inputs and queue the output expected for the new state.
  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input vec_t e, input string nm);
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_imm(input logic [5:0] op, input logic [2:0] aop, input string nm);
    step(1'b0, op, 1'b1, v_fetch(1'b1), {nm, "_fetch"});
    step(1'b0, op, 1'b1, v_decode(),    {nm, "_decode"});
    step(1'b0, op, 1'b1, v_iexec(aop),  {nm, "_exec"});
    step(1'b0, op, 1'b1, v_iwb(),       {nm, "_wb"});
  endtask

  // Monitor: every clock the DUT presents a control word; compare against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %06h expected %06h", nm, got, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = 6'd0; mem_ready = 1'b1;

    // Reset held two cycles, then released.
    step(1'b1, RT, 1'b1, v_zero(), "reset0");
    step(1'b1, RT, 1'b1, v_zero(), "reset1");
    step(1'b0, RT, 1'b1, v_zero(), "reset_release");

    // R-type.
    step(1'b0, RT, 1'b1, v_fetch(1'b1), "r_fetch");
    step(1'b0, RT, 1'b1, v_decode(),    "r_decode");
    step(1'b0, RT, 1'b1, v_rexec(),     "r_exec");
    step(1'b0, RT, 1'b1, v_rwb(),       "r_wb");

    // lw with three stalled MEM_READ cycles.
    step(1'b0, LW, 1'b1, v_fetch(1'b1), "lw_fetch");
    step(1'b0, LW, 1'b1, v_decode(),    "lw_decode");
    step(1'b0, LW, 1'b1, v_memaddr(),   "lw_addr");
    for (int i = 0; i < 3; i++) step(1'b0, LW, 1'b0, v_memread(), "lw_read_wait");
    step(1'b0, LW, 1'b1, v_memread(),   "lw_read_done");
    step(1'b0, LW, 1'b1, v_memwb(),     "lw_wb");

    // sw with two stalled MEM_WRITE cycles; retire only on the accepted cycle.
    step(1'b0, SW, 1'b1, v_fetch(1'b1),     "sw_fetch");
    step(1'b0, SW, 1'b1, v_decode(),        "sw_decode");
    step(1'b0, SW, 1'b1, v_memaddr(),       "sw_addr");
    step(1'b0, SW, 1'b0, v_memwrite(1'b0),  "sw_write_wait0");
    step(1'b0, SW, 1'b0, v_memwrite(1'b0),  "sw_write_wait1");
    step(1'b0, SW, 1'b1, v_memwrite(1'b1),  "sw_write_done");

    // Branches and jump.
    step(1'b0, BNE, 1'b1, v_fetch(1'b1),  "bne_fetch");
    step(1'b0, BNE, 1'b1, v_decode(),     "bne_decode");
    step(1'b0, BNE, 1'b1, v_branch(1'b1), "bne_branch");
    step(1'b0, BEQ, 1'b1, v_fetch(1'b1),  "beq_fetch");
    step(1'b0, BEQ, 1'b1, v_decode(),     "beq_decode");
    step(1'b0, BEQ, 1'b1, v_branch(1'b0), "beq_branch");
    step(1'b0, JMP, 1'b1, v_fetch(1'b1),  "j_fetch");
    step(1'b0, JMP, 1'b1, v_decode(),     "j_decode");
    step(1'b0, JMP, 1'b1, v_jump(),       "j_jump");

    // Immediate ALU ops.
    do_imm(ADDI, 3'b000, "addi");
    do_imm(ANDI, 3'b011, "andi");
    do_imm(ORI,  3'b100, "ori");
    do_imm(SLTI, 3'b101, "slti");

    // Fetch stalls 15 cycles, memory answers on the 16th: the answer beats the timeout.
    for (int i = 0; i < 15; i++) step(1'b0, RT, 1'b0, v_fetch(1'b0), "late_fetch_wait");
    step(1'b0, RT, 1'b1, v_fetch(1'b1), "late_fetch_done");
    step(1'b0, RT, 1'b1, v_decode(),    "late_decode");
    step(1'b0, RT, 1'b1, v_rexec(),     "late_exec");
    step(1'b0, RT, 1'b1, v_rwb(),       "late_wb");

    // Reset during R_EXEC aborts the instruction before write-back.
    step(1'b0, RT, 1'b1, v_fetch(1'b1), "abort_fetch");
    step(1'b0, RT, 1'b1, v_decode(),    "abort_decode");
    step(1'b1, RT, 1'b1, v_rexec(),     "abort_exec");
    step(1'b0, RT, 1'b1, v_zero(),      "abort_reset");

    // Illegal opcode traps and stays trapped until reset.
    step(1'b0, ILL, 1'b1, v_fetch(1'b1), "ill_fetch");
    step(1'b0, ILL, 1'b1, v_decode(),    "ill_decode");
    for (int i = 0; i < 10; i++) step(1'b0, ILL, 1'(i % 2), v_trap(2'b01), "ill_trap_hold");
    step(1'b1, RT, 1'b0, v_trap(2'b01), "ill_trap_rst");
    step(1'b0, RT, 1'b0, v_zero(),      "ill_exit_reset");

    // Fetch stalls forever: exactly 16 FETCH cycles, then timeout trap.
    for (int i = 0; i < 16; i++) step(1'b0, RT, 1'b0, v_fetch(1'b0), "to_fetch_wait");
    for (int i = 0; i < 3; i++)  step(1'b0, RT, 1'b1, v_trap(2'b10), "to_trap_hold");
    step(1'b1, RT, 1'b1, v_trap(2'b10), "to_trap_rst");
    step(1'b0, RT, 1'b1, v_zero(),      "to_exit_reset");

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
